// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS core: instruction field encodings,
// ALU operation set and the default text-segment base address.
package mips_pkg;

  localparam logic [31:0] TEXT_BASE_DEFAULT = 32'h0040_0000;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_ANDI  = 6'h0C,
    OP_ORI   = 6'h0D,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_t;

  typedef enum logic [5:0] {
    FN_SLL  = 6'h00,
    FN_SRL  = 6'h02,
    FN_ADD  = 6'h20,
    FN_ADDU = 6'h21,
    FN_SUB  = 6'h22,
    FN_SUBU = 6'h23,
    FN_AND  = 6'h24,
    FN_OR   = 6'h25,
    FN_SLT  = 6'h2A
  } funct_t;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_SLL,
    ALU_SRL
  } alu_op_t;

endpackage

// File: rtl/mips_if.sv
// Data-memory bus between the core datapath (master) and the data memory (slave).
interface mips_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              we;

  modport master (output addr, output wdata, output we, input rdata);
  modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/mips_alu.sv
// Combinational 32-bit wrap-around ALU; slt compares as signed.
module mips_alu
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  alu_op_t                  op,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic        [4:0]        shamt,
  output logic signed [DATA_W-1:0] y
);
  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = {{(DATA_W-1){1'b0}}, (a < b)};
      ALU_SLL: y = b << shamt;
      ALU_SRL: y = b >> shamt;
      default: y = '0;
    endcase
  end
endmodule

// File: rtl/mips_dmem.sv
// Data memory: combinational read, rising-edge write; byte offset bits are ignored.
`include "mips_header.svh"
module mips_dmem #(
  parameter int DEPTH  = `DATA_MEM_DEPTH,
  parameter int DATA_W = 32
) (
  input logic   clk,
  mips_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] data_mem_ff [DEPTH];
  logic [AW-1:0]     idx;
  logic              unused_lsb;

  assign unused_lsb = ^bus.addr[1:0];
  assign idx        = AW'(bus.addr[31:2] % 30'(DEPTH));
  assign bus.rdata  = data_mem_ff[idx];

  always_ff @(posedge clk) begin
    if (bus.we) data_mem_ff[idx] <= bus.wdata;
  end
endmodule

// File: rtl/mips_header.svh
// Shared build constants for the MIPS core.
`ifndef MIPS_HEADER_SVH
`define MIPS_HEADER_SVH
`define DATA_MEM_DEPTH 64
`endif

// File: rtl/mips_imem.sv
// Instruction memory, word-indexed relative to the text base and wrapped to its depth.
module mips_imem #(
  parameter logic [31:0] TEXT_BASE = 32'h0040_0000,
  parameter int          DEPTH     = 512,
  parameter int          DATA_W    = 32
) (
  input  logic [31:0]       pc,
  output logic [DATA_W-1:0] instr
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] regData [DEPTH];
  logic [AW-1:0]     idx;

  assign idx   = AW'(((pc - TEXT_BASE) >> 2) % 32'(DEPTH));
  assign instr = regData[idx];
endmodule

// File: rtl/mips_regbank.sv
// 32-entry register file, two combinational read ports; register 0 is hardwired to zero.
module mips_regbank #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic [4:0]        ra1,
  input  logic [4:0]        ra2,
  input  logic [4:0]        wa,
  input  logic              we,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);
  logic [DATA_W-1:0] reg_file_ff [32];

  assign rd1 = (ra1 == 5'd0) ? '0 : reg_file_ff[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : reg_file_ff[ra2];

  always_ff @(posedge clk) begin
    if (we && (wa != 5'd0)) reg_file_ff[wa] <= wd;
  end
endmodule

// File: rtl/mips_core.sv
// Single-cycle MIPS core top with inline control decode.
// Build option: MIPS_SHIFT_EN enables sll/srl; otherwise they decode as nops.
`include "mips_header.svh"
module mips_core
  import mips_pkg::*;
#(
  parameter logic [31:0] TEXT_BASE      = TEXT_BASE_DEFAULT,
  parameter int          IMEM_DEPTH     = 512,
  parameter int          DATA_MEM_DEPTH = `DATA_MEM_DEPTH,
  parameter int          DATA_W         = 32
) (
  input logic clk,
  input logic rst
);
  logic        [31:0]       pc, pc_plus4, pc_next, br_target, j_target;
  logic        [DATA_W-1:0] instr, wb_val;
  logic        [5:0]        opc, fn;
  logic        [4:0]        rs, rt, rd, shamt, wa;
  logic        [15:0]       imm;
  logic signed [DATA_W-1:0] imm_sext, rs_val, rt_val, alu_b, alu_y;
  logic                     reg_we, mem_we, mem_to_reg, use_imm, zext_imm, dst_rt;
  logic                     is_beq, is_bne, is_j, take_br;
  alu_op_t                  alu_op;

  mips_if #(.DATA_W(DATA_W)) dbus ();

  // Fetch
  mips_imem #(.TEXT_BASE(TEXT_BASE), .DEPTH(IMEM_DEPTH), .DATA_W(DATA_W)) InstructionMemory (
    .pc(pc), .instr(instr)
  );

  assign opc      = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign shamt    = instr[10:6];
  assign fn       = instr[5:0];
  assign imm      = instr[15:0];
  assign imm_sext = {{16{imm[15]}}, imm};

  // Decode: every unlisted opcode/funct falls through to the all-zero nop controls
  always_comb begin
    reg_we     = 1'b0;
    mem_we     = 1'b0;
    mem_to_reg = 1'b0;
    use_imm    = 1'b0;
    zext_imm   = 1'b0;
    dst_rt     = 1'b0;
    is_beq     = 1'b0;
    is_bne     = 1'b0;
    is_j       = 1'b0;
    alu_op     = ALU_ADD;
    case (opc)
      OP_RTYPE: begin
        case (fn)
          FN_ADD, FN_ADDU: begin reg_we = 1'b1; alu_op = ALU_ADD; end
          FN_SUB, FN_SUBU: begin reg_we = 1'b1; alu_op = ALU_SUB; end
          FN_AND:          begin reg_we = 1'b1; alu_op = ALU_AND; end
          FN_OR:           begin reg_we = 1'b1; alu_op = ALU_OR;  end
          FN_SLT:          begin reg_we = 1'b1; alu_op = ALU_SLT; end
`ifdef MIPS_SHIFT_EN
          FN_SLL:          begin reg_we = 1'b1; alu_op = ALU_SLL; end
          FN_SRL:          begin reg_we = 1'b1; alu_op = ALU_SRL; end
`endif
          default: ;
        endcase
      end
      OP_ADDI: begin reg_we = 1'b1; use_imm = 1'b1; dst_rt = 1'b1; end
      OP_ANDI: begin reg_we = 1'b1; use_imm = 1'b1; dst_rt = 1'b1; zext_imm = 1'b1; alu_op = ALU_AND; end
      OP_ORI:  begin reg_we = 1'b1; use_imm = 1'b1; dst_rt = 1'b1; zext_imm = 1'b1; alu_op = ALU_OR;  end
      OP_LW:   begin reg_we = 1'b1; use_imm = 1'b1; dst_rt = 1'b1; mem_to_reg = 1'b1; end
      OP_SW:   begin mem_we = 1'b1; use_imm = 1'b1; end
      OP_BEQ:  is_beq = 1'b1;
      OP_BNE:  is_bne = 1'b1;
      OP_J:    is_j = 1'b1;
      default: ;
    endcase
  end

  // Register read / execute
  assign wa = dst_rt ? rt : rd;

  mips_regbank #(.DATA_W(DATA_W)) RegBank (
    .clk(clk), .ra1(rs), .ra2(rt), .wa(wa), .we(reg_we & ~rst),
    .wd(wb_val), .rd1(rs_val), .rd2(rt_val)
  );

  assign alu_b = use_imm ? (zext_imm ? $signed({16'h0, imm}) : imm_sext) : rt_val;

  mips_alu #(.DATA_W(DATA_W)) u_alu (
    .op(alu_op), .a(rs_val), .b(alu_b), .shamt(shamt), .y(alu_y)
  );

  // Memory access / writeback; reset suppresses all architectural writes
  assign dbus.addr  = alu_y;
  assign dbus.wdata = rt_val;
  assign dbus.we    = mem_we & ~rst;

  mips_dmem #(.DEPTH(DATA_MEM_DEPTH), .DATA_W(DATA_W)) DataMemory (
    .clk(clk), .bus(dbus)
  );

  assign wb_val = mem_to_reg ? dbus.rdata : alu_y;

  // Next PC
  assign pc_plus4  = pc + 32'd4;
  assign br_target = pc_plus4 + {imm_sext[29:0], 2'b00};
  assign j_target  = {pc_plus4[31:28], instr[25:0], 2'b00};
  assign take_br   = (is_beq && (rs_val == rt_val)) || (is_bne && (rs_val != rt_val));
  assign pc_next   = is_j ? j_target : (take_br ? br_target : pc_plus4);

  always_ff @(posedge clk) begin
    if (rst) pc <= TEXT_BASE;
    else     pc <= pc_next;
  end
endmodule

// File: tb/tb_mips_core.sv
// Directed bench for mips_core: preloads programs/data hierarchically during reset
// and checks registers, data memory and PC against hand-computed values.
module tb_mips_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  localparam logic [31:0] TB_TEXT = 32'h0040_0000;

  always #5 clk = ~clk;

  mips_core dut (.clk(clk), .rst(rst));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic begin_prog();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 512; i++) dut.InstructionMemory.regData[i] <= 32'h0;
  endtask

  task automatic ld(input int idx, input logic [31:0] w);
    dut.InstructionMemory.regData[idx] <= w;
  endtask

  task automatic run(input int n);
    @(negedge clk);
    rst = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  logic [31:0] idx0, idx1;

  initial begin
    // Reset: held 6 cycles, preloads survive
    begin_prog();
    dut.RegBank.reg_file_ff[31]            <= 32'h1001_0000;
    dut.DataMemory.data_mem_ff[5]          <= 32'hDEAD_BEEF;
    dut.InstructionMemory.regData[100]     <= 32'h1234_5678;
    repeat (6) @(negedge clk);
    chk("reset_pc", dut.pc, TB_TEXT);
    chk("reset_r31", dut.RegBank.reg_file_ff[31], 32'h1001_0000);
    chk("reset_dmem5", dut.DataMemory.data_mem_ff[5], 32'hDEAD_BEEF);
    chk("reset_imem100", dut.InstructionMemory.regData[100], 32'h1234_5678);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("pc_after_3", dut.pc, TB_TEXT + 32'd12);
    chk("r31_after", dut.RegBank.reg_file_ff[31], 32'h1001_0000);

    // ALU
    begin_prog();
    ld(1, 32'h2001_0005);  // addi $1,$0,5
    ld(2, 32'h2002_FFFD);  // addi $2,$0,-3
    ld(3, 32'h0022_1820);  // add  $3,$1,$2
    ld(4, 32'h0041_202A);  // slt  $4,$2,$1
    ld(5, 32'h0022_2822);  // sub  $5,$1,$2
    ld(6, 32'h3047_FFFF);  // andi $7,$2,0xFFFF
    ld(7, 32'h3408_8000);  // ori  $8,$0,0x8000
    ld(8, 32'h0022_482A);  // slt  $9,$1,$2
    run(12);
    chk("alu_r3", dut.RegBank.reg_file_ff[3], 32'd2);
    chk("alu_r4", dut.RegBank.reg_file_ff[4], 32'd1);
    chk("alu_r2", dut.RegBank.reg_file_ff[2], 32'hFFFF_FFFD);
    chk("alu_sub", dut.RegBank.reg_file_ff[5], 32'd8);
    chk("alu_andi", dut.RegBank.reg_file_ff[7], 32'h0000_FFFD);
    chk("alu_ori", dut.RegBank.reg_file_ff[8], 32'h0000_8000);
    chk("alu_slt0", dut.RegBank.reg_file_ff[9], 32'd0);

    // Memory, including store-to-load and address wrap
    begin_prog();
    dut.DataMemory.data_mem_ff[0] <= 32'h0000_0055;
    dut.DataMemory.data_mem_ff[2] <= 32'd7;
    dut.DataMemory.data_mem_ff[3] <= 32'd0;
    ld(1, 32'h2001_0008);  // addi $1,$0,8
    ld(2, 32'h8C22_0000);  // lw   $2,0($1)
    ld(3, 32'hAC22_0004);  // sw   $2,4($1)
    ld(4, 32'h8C23_0004);  // lw   $3,4($1)
    ld(5, 32'h8C04_0100);  // lw   $4,256($0)
    run(8);
    chk("mem_d3", dut.DataMemory.data_mem_ff[3], 32'd7);
    chk("mem_lw_r2", dut.RegBank.reg_file_ff[2], 32'd7);
    chk("mem_st_ld", dut.RegBank.reg_file_ff[3], 32'd7);
    chk("mem_wrap", dut.RegBank.reg_file_ff[4], 32'h0000_0055);

    // Minimum search
    begin_prog();
    ld(1, 32'h0000_0820); ld(2, 32'h2002_0024); ld(3, 32'h8C23_0000);
    ld(4, 32'h2021_0004); ld(5, 32'h8C24_0000); ld(6, 32'h0083_282A);
    ld(7, 32'h10A0_0001); ld(8, 32'h0080_1820); ld(9, 32'h1022_0001);
    ld(10, 32'h0810_0004); ld(11, 32'hAC23_0004); ld(12, 32'h2000_0000);
    ld(13, 32'h0810_000C);
    for (int i = 0; i < 10; i++) dut.DataMemory.data_mem_ff[i] <= 32'(10 - i);
    dut.DataMemory.data_mem_ff[10] <= 32'hFFFF_FFFF;
    run(300);
    chk("min_d10", dut.DataMemory.data_mem_ff[10], 32'd1);
    chk("min_r1", dut.RegBank.reg_file_ff[1], 32'd36);
    chk("min_r3", dut.RegBank.reg_file_ff[3], 32'd1);
    idx0 = (dut.pc - TB_TEXT) >> 2;
    chk("spin_range", {31'd0, (idx0 == 32'd12) || (idx0 == 32'd13)}, 32'd1);
    @(negedge clk);
    idx1 = (dut.pc - TB_TEXT) >> 2;
    chk("spin_next", idx1, (idx0 == 32'd12) ? 32'd13 : 32'd12);

    // r0 writes, bne, unsupported funct
    begin_prog();
    dut.RegBank.reg_file_ff[2] <= 32'h0000_00AA;
    dut.RegBank.reg_file_ff[5] <= 32'h0000_5A5A;
    ld(1, 32'h2000_0009);  // addi $0,$0,9
    ld(2, 32'h2001_0001);  // addi $1,$0,1
    ld(3, 32'h1420_0001);  // bne  $1,$0,+1
    ld(4, 32'h2002_0007);  // addi $2,$0,7 (skipped)
    ld(5, 32'h2003_0009);  // addi $3,$0,9
    ld(6, 32'h0001_2826);  // funct 0x26: nop
    run(10);
    chk("r0_zero", dut.RegBank.rd1, 32'd0);
    chk("bne_skip", dut.RegBank.reg_file_ff[2], 32'h0000_00AA);
    chk("bne_tgt", dut.RegBank.reg_file_ff[3], 32'd9);
    chk("unsup_nop", dut.RegBank.reg_file_ff[5], 32'h0000_5A5A);

    // Shift
    begin_prog();
    dut.RegBank.reg_file_ff[1] <= 32'd3;
    dut.RegBank.reg_file_ff[2] <= 32'h0000_1234;
    dut.RegBank.reg_file_ff[3] <= 32'h0000_0077;
    ld(1, 32'h0001_1100);  // sll $2,$1,4
    ld(2, 32'h0001_1842);  // srl $3,$1,1
    run(5);
`ifdef MIPS_SHIFT_EN
    chk("sll", dut.RegBank.reg_file_ff[2], 32'd48);
    chk("srl", dut.RegBank.reg_file_ff[3], 32'd1);
`else
    chk("sll_nop", dut.RegBank.reg_file_ff[2], 32'h0000_1234);
    chk("srl_nop", dut.RegBank.reg_file_ff[3], 32'h0000_0077);
`endif

    // Reset mid-program
    begin_prog();
    dut.RegBank.reg_file_ff[1] <= 32'd3;
    ld(1, 32'h2021_0001); ld(2, 32'h2021_0001); ld(3, 32'h2021_0001);
    run(2);
    chk("mid_pc", dut.pc, TB_TEXT + 32'd8);
    chk("mid_r1", dut.RegBank.reg_file_ff[1], 32'd4);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_pc", dut.pc, TB_TEXT);
    chk("mid_rst_r1", dut.RegBank.reg_file_ff[1], 32'd4);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_resume", dut.RegBank.reg_file_ff[1], 32'd5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
